// File: rtl/posit_decode_pkg.sv
// Shared widths and types for the posit decoder.
// Width helpers keep derived sizes consistent between the pipe and its users.
package posit_decode_pkg;

  localparam int DEF_N_BITS  = 16;
  localparam int DEF_ES_BITS = 2;

  function automatic int calc_scale_w(input int n_bits, input int es_bits);
    return $clog2(n_bits) + es_bits + 1;
  endfunction

  function automatic int calc_frac_w(input int n_bits, input int es_bits);
    return n_bits - 3 - es_bits;
  endfunction

  localparam int DEF_SCALE_W = calc_scale_w(DEF_N_BITS, DEF_ES_BITS);
  localparam int DEF_FRAC_W  = calc_frac_w(DEF_N_BITS, DEF_ES_BITS);

  typedef struct packed {
    logic                   sign;
    logic [DEF_SCALE_W-1:0] scale;
    logic [DEF_FRAC_W:0]    mant;
    logic                   zero;
    logic                   nar;
  } posit_decoded_t;

endpackage

// File: rtl/posit_regime_detect.sv
// Regime run-length detector: counts the leading run of the posit body and
// returns the bits after the run terminator, left-aligned and zero-filled.
module posit_regime_detect import posit_decode_pkg::*; #(
  parameter  int N_BITS = DEF_N_BITS,
  localparam int KW     = $clog2(N_BITS)
) (
  input  logic [N_BITS-2:0] body,
  output logic [KW-1:0]     k,
  output logic [N_BITS-4:0] rem
);

  logic [N_BITS-2:0] inv;
  logic [KW-1:0]     pos;
  logic              found;

  // Inverting on polarity turns the run into leading zeros for both signs of regime.
  assign inv = body[N_BITS-2] ? ~body : body;

  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < N_BITS-1; i++) begin
      if (inv[i]) begin
        pos   = KW'(i);
        found = 1'b1;
      end
    end
  end

  assign k = found ? (KW'(N_BITS-2) - pos) : KW'(N_BITS-1);

  // The top two body bits are always consumed (k >= 1 plus terminator), so
  // shifting the lower body by k-1 equals skipping k+1 bits of the full body.
  assign rem = body[N_BITS-4:0] << (k - KW'(1));

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder with valid/ready on both sides.
// Define POSIT_DECODE_TAG_EN to carry a TAG_W-bit sideband tag with each word.
module posit_decode_pipe import posit_decode_pkg::*; #(
  parameter  int N_BITS  = DEF_N_BITS,
  parameter  int ES_BITS = DEF_ES_BITS,
`ifdef POSIT_DECODE_TAG_EN
  parameter  int TAG_W   = 4,
`endif
  localparam int SCALE_W = calc_scale_w(N_BITS, ES_BITS),
  localparam int FRAC_W  = calc_frac_w(N_BITS, ES_BITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_BITS-1:0]  in_posit,
`ifdef POSIT_DECODE_TAG_EN
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [SCALE_W-1:0] out_scale,
  output logic [FRAC_W:0]    out_mant,
  output logic               out_zero,
  output logic               out_nar
);

  localparam int STAGES = 2;
  localparam int KW     = $clog2(N_BITS);

  logic [STAGES:1]   vld_pipe;
  logic              s1_en, s2_en;
  logic              s1_sign, s1_zero, s1_nar;
  logic [N_BITS-2:0] s1_body;
  logic [N_BITS-2:0] body_d;
`ifdef POSIT_DECODE_TAG_EN
  logic [TAG_W-1:0]  s1_tag;
`endif

  assign s2_en     = !vld_pipe[2] || out_ready;
  assign s1_en     = !vld_pipe[1] || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = vld_pipe[2];

  // Low bits of the two's complement are all that the body needs.
  assign body_d = in_posit[N_BITS-1] ? -in_posit[N_BITS-2:0] : in_posit[N_BITS-2:0];

  logic [KW-1:0]      k;
  logic [N_BITS-4:0]  rem;
  logic [SCALE_W-1:0] k_x, r_val, scale_d;
  logic [FRAC_W:0]    mant_d;
  logic               special;

  posit_regime_detect #(.N_BITS(N_BITS)) u_regime (
    .body (s1_body),
    .k    (k),
    .rem  (rem)
  );

  assign k_x     = SCALE_W'(k);
  assign r_val   = s1_body[N_BITS-2] ? (k_x - SCALE_W'(1)) : (SCALE_W'(0) - k_x);
  // Exponent sits in the top ES_BITS of rem; the low bits of r<<ES are free for it.
  assign scale_d = (r_val << ES_BITS) | SCALE_W'(rem >> FRAC_W);
  assign mant_d  = {1'b1, rem[FRAC_W-1:0]};
  assign special = s1_zero || s1_nar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
      s1_body   <= '0;
      out_sign  <= 1'b0;
      out_scale <= '0;
      out_mant  <= '0;
      out_zero  <= 1'b0;
      out_nar   <= 1'b0;
`ifdef POSIT_DECODE_TAG_EN
      s1_tag    <= '0;
      out_tag   <= '0;
`endif
    end else begin
      if (s1_en) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_sign <= in_posit[N_BITS-1];
          s1_zero <= (in_posit == '0);
          s1_nar  <= (in_posit == {1'b1, {(N_BITS-1){1'b0}}});
          s1_body <= body_d;
`ifdef POSIT_DECODE_TAG_EN
          s1_tag  <= in_tag;
`endif
        end
      end
      if (s2_en) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_sign  <= s1_sign;
          out_scale <= special ? '0 : scale_d;
          out_mant  <= special ? '0 : mant_d;
          out_zero  <= s1_zero;
          out_nar   <= s1_nar;
`ifdef POSIT_DECODE_TAG_EN
          out_tag   <= s1_tag;
`endif
        end
      end
    end
  end

endmodule
